// File: rtl/counter_pkg.sv
// Shared definitions for the counter family (up counters and counter_down).
package counter_pkg;

    localparam int unsigned STATE_W         = 2;
    localparam int unsigned COUNT_W_DEFAULT = 7;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/counter_down.sv
// Loadable down counter / interval timer with one-shot or auto-reload
// operation, pause/resume, and a registered terminal-count pulse.
module counter_down
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] reload_reg;

    // FSM and count datapath; priority is reset > load > start > pause > count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            q          <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                reload_reg <= load_val;
                q          <= load_val;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (q != '0) begin
                                state <= RUN;
                            end else begin
                                tc    <= 1'b1;
                                state <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (start) begin
                            q <= reload_reg;
                            if (reload_reg == '0) begin
                                tc <= 1'b1;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state <= HOLD;
                        end else if (q > ONE) begin
                            q <= q - ONE;
                        end else if (q == ONE) begin
                            q  <= '0;
                            tc <= 1'b1;
                            if (!auto_reload) begin
                                state <= DONE;
                            end
                        end else if (reload_reg != '0) begin
                            // q reached 0 while periodic: reload for the next period
                            q <= reload_reg;
                        end else begin
                            // zero reload: every cycle is a terminal count
                            tc <= 1'b1;
                            if (!auto_reload) begin
                                state <= DONE;
                            end
                        end
                    end
                    HOLD: begin
                        if (!pause) begin
                            state <= RUN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Status levels decoded straight from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN, HOLD: busy = 1'b1;
            DONE:      done = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_counter_down.sv
// Directed, table-driven bench for counter_down.
module tb_counter_down;

    localparam int unsigned W = 7;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         pause;
    logic         auto_reload;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic         ld;
        logic [W-1:0] lv;
        logic         st;
        logic         pa;
        logic         ar;
        logic [W-1:0] eq;
        logic         etc;
        logic         eb;
        logic         ed;
    } vec_t;

    vec_t vecs[$];

    counter_down #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .load_val(load_val),
        .start(start),
        .pause(pause),
        .auto_reload(auto_reload),
        .q(q),
        .tc(tc),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int eq, input int etc,
                           input int eb, input int ed);
        chk({tag, " q"},    int'(q),    eq);
        chk({tag, " tc"},   int'(tc),   etc);
        chk({tag, " busy"}, int'(busy), eb);
        chk({tag, " done"}, int'(done), ed);
    endtask

    task automatic drive(input logic ld, input int lv, input logic st,
                         input logic pa, input logic ar);
        load        = ld;
        load_val    = W'(lv);
        start       = st;
        pause       = pa;
        auto_reload = ar;
    endtask

    // apply current inputs across one rising edge, then sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic ld, input int lv, input logic st, input logic pa,
                       input logic ar, input int eq, input logic etc,
                       input logic eb, input logic ed);
        vec_t v;
        v.ld = ld; v.lv = W'(lv); v.st = st; v.pa = pa; v.ar = ar;
        v.eq = W'(eq); v.etc = etc; v.eb = eb; v.ed = ed;
        vecs.push_back(v);
    endtask

    initial begin
        //    ld lv  st pa ar   q  tc b  d
        // one-shot from 5
        add(1, 5,  0, 0, 0,   5, 0, 0, 0);
        add(0, 0,  1, 0, 0,   5, 0, 1, 0);
        add(0, 0,  0, 0, 0,   4, 0, 1, 0);
        add(0, 0,  0, 0, 0,   3, 0, 1, 0);
        add(0, 0,  0, 0, 0,   2, 0, 1, 0);
        add(0, 0,  0, 0, 0,   1, 0, 1, 0);
        add(0, 0,  0, 0, 0,   0, 1, 0, 1);
        add(0, 0,  0, 0, 0,   0, 0, 0, 1);
        // restart from DONE reloads 5; start in RUN ignored
        add(0, 0,  1, 0, 0,   5, 0, 1, 0);
        add(0, 0,  1, 0, 0,   4, 0, 1, 0);
        // periodic from 3, then drop auto_reload
        add(1, 3,  0, 0, 0,   3, 0, 0, 0);
        add(0, 0,  1, 0, 1,   3, 0, 1, 0);
        add(0, 0,  0, 0, 1,   2, 0, 1, 0);
        add(0, 0,  0, 0, 1,   1, 0, 1, 0);
        add(0, 0,  0, 0, 1,   0, 1, 1, 0);
        add(0, 0,  0, 0, 1,   3, 0, 1, 0);
        add(0, 0,  0, 0, 1,   2, 0, 1, 0);
        add(0, 0,  0, 0, 1,   1, 0, 1, 0);
        add(0, 0,  0, 0, 1,   0, 1, 1, 0);
        add(0, 0,  0, 0, 1,   3, 0, 1, 0);
        add(0, 0,  0, 0, 1,   2, 0, 1, 0);
        add(0, 0,  0, 0, 0,   1, 0, 1, 0);
        add(0, 0,  0, 0, 0,   0, 1, 0, 1);
        add(0, 0,  0, 0, 0,   0, 0, 0, 1);
        // pause 3 cycles at 7, one extra cycle to resume
        add(1, 10, 0, 0, 0,  10, 0, 0, 0);
        add(0, 0,  1, 0, 0,  10, 0, 1, 0);
        add(0, 0,  0, 0, 0,   9, 0, 1, 0);
        add(0, 0,  0, 0, 0,   8, 0, 1, 0);
        add(0, 0,  0, 0, 0,   7, 0, 1, 0);
        add(0, 0,  0, 1, 0,   7, 0, 1, 0);
        add(0, 0,  0, 1, 0,   7, 0, 1, 0);
        add(0, 0,  0, 1, 0,   7, 0, 1, 0);
        add(0, 0,  0, 0, 0,   7, 0, 1, 0);
        add(0, 0,  0, 0, 0,   6, 0, 1, 0);
        add(0, 0,  0, 0, 0,   5, 0, 1, 0);
        // zero load: immediate tc; restart from DONE with zero reload
        add(1, 0,  0, 0, 0,   0, 0, 0, 0);
        add(0, 0,  1, 0, 0,   0, 1, 0, 1);
        add(0, 0,  0, 0, 0,   0, 0, 0, 1);
        add(0, 0,  1, 0, 0,   0, 1, 0, 1);
        add(0, 0,  0, 0, 0,   0, 0, 0, 1);
        // start beats pause in IDLE, then pause takes RUN to HOLD
        add(1, 2,  0, 0, 0,   2, 0, 0, 0);
        add(0, 0,  1, 1, 0,   2, 0, 1, 0);
        add(0, 0,  0, 1, 0,   2, 0, 1, 0);
        add(0, 0,  0, 0, 0,   2, 0, 1, 0);
        add(0, 0,  0, 0, 0,   1, 0, 1, 0);
        add(0, 0,  0, 0, 0,   0, 1, 0, 1);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        chk_all("reset1", 0, 0, 0, 0);
        tick();
        chk_all("reset2", 0, 0, 0, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].ld, int'(vecs[i].lv), vecs[i].st, vecs[i].pa, vecs[i].ar);
            tick();
            chk_all($sformatf("vec%0d", i), int'(vecs[i].eq), int'(vecs[i].etc),
                    int'(vecs[i].eb), int'(vecs[i].ed));
        end

        // reset held 2 cycles while running at q=40
        drive(1, 50, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick();
        chk_all("run_to_40", 40, 0, 1, 0);
        reset = 1'b1;
        tick();
        chk_all("midrun_reset1", 0, 0, 0, 0);
        tick();
        chk_all("midrun_reset2", 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        chk_all("post_reset_idle", 0, 0, 0, 0);

        // load while running at q=40 abandons the count
        drive(1, 50, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) tick();
        drive(0, 0, 1, 0, 0);
        tick();
        chk_all("start_in_run_ignored", 40, 0, 1, 0);
        drive(1, 100, 0, 0, 0);
        tick();
        chk_all("load_during_run", 100, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        tick();
        chk_all("load_stays_idle", 100, 0, 0, 0);

        // full-scale count from 127: no wrap, tc only at 0
        drive(1, 127, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 0);
        tick();
        chk_all("max_start", 127, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        for (int n = 126; n >= 1; n--) begin
            tick();
            chk(.nm("max_q"), .act(int'(q)), .exp(n));
            chk(.nm("max_tc"), .act(int'(tc)), .exp(0));
        end
        tick();
        chk_all("max_tc_at_zero", 0, 1, 0, 1);
        tick();
        chk_all("max_no_wrap", 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_down.md
# counter_down

Loadable down counter / interval timer: the counting counterpart to the free-running up counter already in the sequential library. It is loaded with a start value, counts toward zero on command, and flags terminal count. It supports one-shot or auto-reload (periodic) operation, pause/resume, and reports state through `busy` and `done` levels. It is used as a programmable delay or tick generator beside the existing counters.

## Interface
- `WIDTH`, default 7: counter and load-value width.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `load` in 1: capture `load_val` into the reload register and `q`.
- `load_val` in WIDTH: start/reload value.
- `start` in 1: begin counting; sampled in IDLE and DONE only.
- `pause` in 1: level; freezes counting while high.
- `auto_reload` in 1: level; 1 = periodic, 0 = one-shot. Sampled at terminal count.
- `q` out WIDTH: current count, registered.
- `tc` out 1: registered one-cycle pulse, high in the cycle `q` becomes 0.
- `busy` out 1: high in RUN or HOLD.
- `done` out 1: high in DONE.

## Operation
- Internal: state register (IDLE, RUN, HOLD, DONE) and `reload_reg` [WIDTH].
- Priority each edge: reset > load > start > pause > count.
- Reset: state IDLE, `q`=0, `reload_reg`=0, `tc`=0, `busy`=0, `done`=0.
- load (any state): `reload_reg`<=`load_val`, `q`<=`load_val`, state IDLE, `tc`<=0. An in-flight count is abandoned with no `tc`.
- IDLE + start:
  - If `q`!=0: go to RUN; `q` unchanged.
  - If `q`==0: pulse `tc`, go to DONE.
- DONE + start: `q`<=`reload_reg`, then go to RUN.
  - If `reload_reg`==0: pulse `tc` and stay in DONE.
- RUN, pause=0, `q`>1: `q`<=`q`-1.
- RUN, pause=0, `q`==1: `q`<=0, `tc`<=1.
  - `auto_reload`=0: go to DONE.
  - `auto_reload`=1: stay in RUN.
- RUN, pause=0, `q`==0 (auto-reload only): `q`<=`reload_reg`.
  - If `reload_reg`==0: `q` stays 0 and `tc` pulses every cycle.
- RUN + pause: go to HOLD; `q` held.
- HOLD + !pause: go to RUN; `q` held that cycle, so resume costs one cycle.
- start in RUN or HOLD is ignored.
- Arithmetic: unsigned, WIDTH bits. `q` never decrements below 0; there is no wrap to all-ones.
- `tc` is 0 in every cycle not listed above.

## Timing
- Start accepted at edge k with `q`=N>0:
  - First decrement at edge k+1.
  - `q`=0 and `tc`=1 after edge k+N.
  - One-shot: `done`=1 from edge k+N.
- Auto-reload period: N+1 cycles per `tc` (N, N-1, …, 0).
- `busy` and `done` are decoded from the state register. They are glitch-free and change on the same edge as the state.
- Load-to-`q` latency: 1 edge. Start-to-`busy` latency: 1 edge.

## Structure
- Shared package `counter_pkg`:
  - State enum typedef (IDLE, RUN, HOLD, DONE) and `STATE_W`=2.
  - `COUNT_W_DEFAULT`=7, shared with the up counters.
- Single module: FSM plus datapath. No sub-module is warranted; the decrement and zero-detect are one line each.

## Test plan
- Reset held 2 cycles, including mid-RUN at `q`=40 -> `q`=0, `tc`=0, `busy`=0, `done`=0, state IDLE.
- load 5, start, `auto_reload`=0 -> `q` shows 5,4,3,2,1,0 on successive edges. `tc` is high exactly one cycle (with `q`=0). Then `done`=1, `busy`=0, `q` stays 0.
- load 3, start, `auto_reload`=1 -> `q` shows 3,2,1,0,3,2,1,0,… and `tc` pulses every 4 cycles. Dropping `auto_reload` before the next 1->0 step -> DONE after that `tc`.
- load 10, start, pause high 3 cycles when `q`=7 -> `q` holds 7 for 4 cycles, then continues 6,5,…; `busy` stays 1 throughout.
- While RUN at `q`=40, load 100 -> `q`=100 next edge, state IDLE, `busy`=0, no `tc`. A start given during RUN is ignored.
- load 0, start -> `tc` one pulse, `done`=1. load 127 (max), start -> 127 decrements with no wrap, then `tc`.
